// File: rtl/deflate_job_ctrl.sv
// Job sequencer for the HLS deflate core: loads pixels into the image BRAM, runs the core, reports a result.
// Optional macro DEFLATE_SIZE_CHECK_EN reports status 3 when compressed_size disagrees with the byte count.
module deflate_job_ctrl #(
    parameter int ADDR_W         = 12,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [15:0]       cfg_width,
    input  logic [15:0]       cfg_height,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [DATA_W-1:0] pix_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic              core_ce,
    input  logic [ADDR_W-1:0] core_addr,
    output logic              ap_start,
    input  logic              ap_ready,
    input  logic              ap_done,
    input  logic              ap_idle,
    output logic              core_rst,
    output logic [31:0]       width,
    output logic [31:0]       height,
    input  logic              cd_vld,
    input  logic              cs_vld,
    input  logic [31:0]       cs_size,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [31:0]       res_bytes,
    output logic [31:0]       res_size,
    output logic [1:0]        res_status,
    output logic              busy
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_RUN, S_REPORT} state_t;

    localparam int          CNT_W   = ADDR_W + 1;
    localparam logic [31:0] MAX_PIX = 32'(1) << ADDR_W;
    localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ST_OK       = 2'd0;
    localparam logic [1:0] ST_BAD_CFG  = 2'd1;
    localparam logic [1:0] ST_TIMEOUT  = 2'd2;
    localparam logic [1:0] ST_SIZE_BAD = 2'd3;

    state_t            state_q, state_d;
    logic [15:0]       width_q, width_d;
    logic [15:0]       height_q, height_d;
    logic [CNT_W-1:0]  npix_q, npix_d;
    logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_din_q, wr_din_d;
    logic [31:0]       wd_q, wd_d;
    logic              core_rst_q, core_rst_d;
    logic [31:0]       bytes_q, bytes_d;
    logic [31:0]       size_q, size_d;
    logic              cs_seen_q, cs_seen_d;
    logic [1:0]        status_q, status_d;

    logic [31:0] npix_req;
    logic [31:0] bytes_smp;
    logic [31:0] size_smp;
    logic        seen_smp;
    logic [1:0]  done_status;
    logic        core_live;
    logic        own_port;
    logic        unused_ok;

    // Core idle is informational only; completion is tracked through ap_done.
    assign unused_ok = ap_idle;

    always_comb begin
        npix_req  = 32'(cfg_width) * 32'(cfg_height);
        bytes_smp = (cd_vld && (bytes_q != '1)) ? bytes_q + 32'd1 : bytes_q;
        size_smp  = cs_vld ? cs_size : size_q;
        seen_smp  = cs_seen_q | cs_vld;
`ifdef DEFLATE_SIZE_CHECK_EN
        done_status = (!seen_smp || (size_smp != bytes_smp)) ? ST_SIZE_BAD : ST_OK;
`else
        done_status = ST_OK;
`endif
        // The core is considered running from the ap_ready handshake onwards.
        core_live = (state_q == S_RUN) || ((state_q == S_START) && ap_ready);

        state_d    = state_q;
        width_d    = width_q;
        height_d   = height_q;
        npix_d     = npix_q;
        pix_cnt_d  = pix_cnt_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_din_d   = wr_din_q;
        wd_d       = wd_q;
        core_rst_d = 1'b0;
        bytes_d    = bytes_q;
        size_d     = size_q;
        cs_seen_d  = cs_seen_q;
        status_d   = status_q;

        case (state_q)
            S_IDLE: begin
                if (cfg_valid) begin
                    width_d   = cfg_width;
                    height_d  = cfg_height;
                    npix_d    = npix_req[CNT_W-1:0];
                    pix_cnt_d = '0;
                    wd_d      = '0;
                    bytes_d   = '0;
                    size_d    = '0;
                    cs_seen_d = 1'b0;
                    if ((npix_req == 32'd0) || (npix_req > MAX_PIX)) begin
                        status_d = ST_BAD_CFG;
                        state_d  = S_REPORT;
                    end else begin
                        status_d = ST_OK;
                        state_d  = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (pix_valid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = pix_cnt_q[ADDR_W-1:0];
                    wr_din_d  = pix_data;
                    pix_cnt_d = pix_cnt_q + CNT_W'(1);
                    if (pix_cnt_q == (npix_q - CNT_W'(1))) begin
                        state_d = S_START;
                    end
                end
            end
            S_START, S_RUN: begin
                wd_d = wd_q + 32'd1;
                if (core_live) begin
                    bytes_d   = bytes_smp;
                    size_d    = size_smp;
                    cs_seen_d = seen_smp;
                end
                // Watchdog expiry outranks a simultaneous ap_done.
                if (wd_q == WD_LAST) begin
                    core_rst_d = 1'b1;
                    status_d   = ST_TIMEOUT;
                    state_d    = S_REPORT;
                end else if (core_live && ap_done) begin
                    status_d = done_status;
                    state_d  = S_REPORT;
                end else if (core_live) begin
                    state_d = S_RUN;
                end
            end
            S_REPORT: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            width_q    <= '0;
            height_q   <= '0;
            npix_q     <= '0;
            pix_cnt_q  <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_din_q   <= '0;
            wd_q       <= '0;
            core_rst_q <= 1'b0;
            bytes_q    <= '0;
            size_q     <= '0;
            cs_seen_q  <= 1'b0;
            status_q   <= ST_OK;
        end else begin
            state_q    <= state_d;
            width_q    <= width_d;
            height_q   <= height_d;
            npix_q     <= npix_d;
            pix_cnt_q  <= pix_cnt_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_din_q   <= wr_din_d;
            wd_q       <= wd_d;
            core_rst_q <= core_rst_d;
            bytes_q    <= bytes_d;
            size_q     <= size_d;
            cs_seen_q  <= cs_seen_d;
            status_q   <= status_d;
        end
    end

    // The final pixel write lands in the first START cycle, before the core can issue a read.
    assign own_port   = (state_q == S_START) || (state_q == S_RUN);
    assign mem_en     = wr_en_q | (own_port & core_ce);
    assign mem_we     = wr_en_q;
    assign mem_addr   = wr_en_q ? wr_addr_q : (own_port ? core_addr : '0);
    assign mem_din    = wr_din_q;

    assign cfg_ready  = (state_q == S_IDLE);
    assign pix_ready  = (state_q == S_LOAD);
    assign ap_start   = (state_q == S_START);
    assign core_rst   = core_rst_q;
    assign width      = {16'd0, width_q};
    assign height     = {16'd0, height_q};
    assign res_valid  = (state_q == S_REPORT);
    assign res_bytes  = bytes_q;
    assign res_size   = size_q;
    assign res_status = status_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_deflate_job_ctrl.sv
// Bench for deflate_job_ctrl: table of jobs, result and BRAM-write scoreboards, and a small core model.
module tb_deflate_job_ctrl;
    localparam int AW  = 12;
    localparam int DW  = 8;
    localparam int TMO = 1500;
`ifdef DEFLATE_SIZE_CHECK_EN
    localparam int SC_ST = 3;
`else
    localparam int SC_ST = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_valid, cfg_ready;
    logic [15:0]   cfg_width, cfg_height;
    logic          pix_valid, pix_ready;
    logic [DW-1:0] pix_data;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic          core_ce;
    logic [AW-1:0] core_addr;
    logic          ap_start, ap_ready, ap_done, ap_idle, core_rst;
    logic [31:0]   width, height;
    logic          cd_vld, cs_vld;
    logic [31:0]   cs_size;
    logic          res_valid, res_ready;
    logic [31:0]   res_bytes, res_size;
    logic [1:0]    res_status;
    logic          busy;

    always #5 clk = ~clk;

    deflate_job_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_width(cfg_width), .cfg_height(cfg_height),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .core_ce(core_ce), .core_addr(core_addr),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_idle(ap_idle),
        .core_rst(core_rst), .width(width), .height(height),
        .cd_vld(cd_vld), .cs_vld(cs_vld), .cs_size(cs_size),
        .res_valid(res_valid), .res_ready(res_ready), .res_bytes(res_bytes),
        .res_size(res_size), .res_status(res_status), .busy(busy)
    );

    typedef struct {
        int w; int h;
        int ncd; int cs; bit send_cs; bit finish; bit rdy_done;
        int gap; int hold;
        int exp_st; int exp_b; int exp_s;
    } job_t;

    typedef struct packed {
        logic [31:0] b;
        logic [31:0] s;
        logic [1:0]  st;
    } exp_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ap_start_rises = 0;
    int core_rst_pulses = 0;
    int start_cyc = 0;
    logic ap_start_prev = 1'b0;

    exp_t          exp_res_q[$];
    logic [AW+DW-1:0] exp_wr_q[$];

    int core_ncd = 0;
    int core_cs = 0;
    bit core_send_cs = 0;
    bit core_finish = 0;
    bit core_rdy_done = 0;

    job_t jobs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic job_t mk(input int w, input int h, input int ncd, input int cs,
                                input bit send_cs, input bit finish, input bit rdy_done,
                                input int gap, input int hold,
                                input int exp_st, input int exp_b, input int exp_s);
        job_t j;
        j.w = w; j.h = h; j.ncd = ncd; j.cs = cs; j.send_cs = send_cs;
        j.finish = finish; j.rdy_done = rdy_done; j.gap = gap; j.hold = hold;
        j.exp_st = exp_st; j.exp_b = exp_b; j.exp_s = exp_s;
        return j;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Write scoreboard and event counters, sampled on the falling edge.
    initial forever begin
        logic [AW+DW-1:0] e;
        @(negedge clk);
        if (!rst) begin
            if (mem_we) begin
                check("wr_expected", 64'(exp_wr_q.size() != 0), 64'd1);
                check("wr_en_with_we", 64'(mem_en), 64'd1);
                if (exp_wr_q.size() != 0) begin
                    e = exp_wr_q.pop_front();
                    check("wr_addr", 64'(mem_addr), 64'(e[AW+DW-1:DW]));
                    check("wr_data", 64'(mem_din), 64'(e[DW-1:0]));
                end
            end
            if (ap_start && !ap_start_prev) begin
                ap_start_rises++;
                start_cyc = cyc;
            end
            if (core_rst) core_rst_pulses++;
        end
        ap_start_prev = ap_start;
    end

    // Core model: ap_ready after a short delay, then cd_vld burst, optional cs_vld, optional ap_done.
    initial begin
        ap_ready = 0; ap_done = 0; ap_idle = 1; cd_vld = 0; cs_vld = 0;
        cs_size = 0; core_ce = 0; core_addr = '0;
        forever begin
            @(negedge clk);
            if (ap_start && !rst) begin
                ap_idle = 0;
                repeat (3) begin
                    check("ap_start_held", 64'(ap_start), 64'd1);
                    @(negedge clk);
                end
                if (core_rdy_done) begin
                    ap_ready = 1; ap_done = 1; cd_vld = 1; cs_vld = 1; cs_size = 32'(core_cs);
                    @(negedge clk);
                    ap_ready = 0; ap_done = 0; cd_vld = 0; cs_vld = 0;
                    check("ap_start_after_ready", 64'(ap_start), 64'd0);
                end else begin
                    ap_ready = 1;
                    @(negedge clk);
                    ap_ready = 0;
                    check("ap_start_after_ready", 64'(ap_start), 64'd0);
                    for (int i = 0; i < core_ncd; i++) begin
                        cd_vld = 1;
                        core_ce = 1;
                        core_addr = AW'(100 + i);
                        if (i < 3) begin
                            #1;
                            check("port_en", 64'(mem_en), 64'd1);
                            check("port_we", 64'(mem_we), 64'd0);
                            check("port_addr", 64'(mem_addr), 64'(100 + i));
                        end
                        @(negedge clk);
                    end
                    cd_vld = 0;
                    core_ce = 0;
                    if (core_send_cs) begin
                        cs_vld = 1; cs_size = 32'(core_cs);
                        @(negedge clk);
                        cs_vld = 0;
                    end
                    if (core_finish) begin
                        ap_done = 1;
                        @(negedge clk);
                        ap_done = 0;
                    end else begin
                        for (int k = 0; k < TMO + 100 && busy; k++) @(negedge clk);
                    end
                end
                ap_idle = 1;
            end
        end
    end

    task automatic run_job(input job_t j);
        int n, p, k, st0, cr0;
        bit loaded;
        exp_t e;
        logic [31:0] b0, s0;
        logic [1:0] t0;
        n = j.w * j.h;
        loaded = (n > 0) && (n <= (1 << AW));
        for (k = 0; k < 100 && !cfg_ready; k++) @(negedge clk);
        check("cfg_ready_wait", 64'(cfg_ready), 64'd1);
        core_ncd = j.ncd; core_cs = j.cs; core_send_cs = j.send_cs;
        core_finish = j.finish; core_rdy_done = j.rdy_done;
        st0 = ap_start_rises;
        cr0 = core_rst_pulses;
        cfg_valid = 1; cfg_width = 16'(j.w); cfg_height = 16'(j.h);
        e.b = 32'(j.exp_b); e.s = 32'(j.exp_s); e.st = 2'(j.exp_st);
        exp_res_q.push_back(e);
        @(negedge clk);
        cfg_valid = 0;
        if (!loaded) begin
            check("badcfg_immediate", 64'(res_valid), 64'd1);
        end else begin
            p = 0;
            for (k = 0; k < 40000 && p < n; k++) begin
                pix_valid = ($urandom_range(99) >= j.gap);
                pix_data = DW'($urandom);
                if (pix_valid && pix_ready) begin
                    exp_wr_q.push_back({AW'(p), pix_data});
                    p++;
                end
                @(negedge clk);
            end
            pix_valid = 0;
            check("pixels_loaded", 64'(p), 64'(n));
            check("pix_ready_drop", 64'(pix_ready), 64'd0);
        end
        for (k = 0; k < 8000 && !res_valid; k++) @(negedge clk);
        check("res_valid_seen", 64'(res_valid), 64'd1);
        if (j.exp_st == 2) begin
            check("wd_latency", 64'(cyc - start_cyc), 64'(TMO));
            check("core_rst_at_expiry", 64'(core_rst), 64'd1);
        end
        check("res_queue", 64'(exp_res_q.size()), 64'd1);
        if (exp_res_q.size() != 0) begin
            e = exp_res_q.pop_front();
            check("res_bytes", 64'(res_bytes), 64'(e.b));
            check("res_size", 64'(res_size), 64'(e.s));
            check("res_status", 64'(res_status), 64'(e.st));
        end
        check("width_out", 64'(width), 64'(j.w));
        check("height_out", 64'(height), 64'(j.h));
        b0 = res_bytes; s0 = res_size; t0 = res_status;
        for (int i = 0; i < j.hold; i++) begin
            cfg_valid = 1; cfg_width = 16'd16; cfg_height = 16'd16;
            @(negedge clk);
            check("hold_cfg_ready", 64'(cfg_ready), 64'd0);
            check("hold_res_valid", 64'(res_valid), 64'd1);
            check("hold_bytes", 64'(res_bytes), 64'(b0));
            check("hold_size", 64'(res_size), 64'(s0));
            check("hold_status", 64'(res_status), 64'(t0));
        end
        res_ready = 1;
        @(negedge clk);
        res_ready = 0;
        check("post_cfg_ready", 64'(cfg_ready), 64'd1);
        check("post_res_valid", 64'(res_valid), 64'd0);
        check("post_not_busy", 64'(busy), 64'd0);
        cfg_valid = 0;
        @(negedge clk);
        check("ap_start_count", 64'(ap_start_rises - st0), loaded ? 64'd1 : 64'd0);
        check("core_rst_count", 64'(core_rst_pulses - cr0), (j.exp_st == 2) ? 64'd1 : 64'd0);
        check("wr_queue_drained", 64'(exp_wr_q.size()), 64'd0);
    endtask

    initial begin
        int cnt;
        rst = 1; cfg_valid = 0; cfg_width = 0; cfg_height = 0;
        pix_valid = 0; pix_data = 0; res_ready = 0;

        jobs[0] = mk(64, 64, 1234, 1234, 1, 1, 0,  0,  0, 0,     1234, 1234);
        jobs[1] = mk( 0, 64,    0,    0, 0, 0, 0,  0,  0, 1,        0,    0);
        jobs[2] = mk(65, 64,    0,    0, 0, 0, 0,  0,  0, 1,        0,    0);
        jobs[3] = mk(16, 16,   10,   10, 1, 1, 0, 40, 50, 0,       10,   10);
        jobs[4] = mk( 4,  4,  100,   99, 1, 1, 0,  0,  0, SC_ST,  100,   99);
        jobs[5] = mk( 2,  2,    5,    0, 0, 1, 0,  0,  0, SC_ST,    5,    0);
        jobs[6] = mk( 1,  1,    0,    1, 1, 1, 1,  0,  0, 0,        1,    1);
        jobs[7] = mk( 3,  3,    7,    0, 0, 0, 0,  0,  0, 2,        7,    0);
        jobs[8] = mk( 1, 4097,  0,    0, 0, 0, 0,  0,  0, 1,        0,    0);

        repeat (3) @(negedge clk);
        check("rst_cfg_ready", 64'(cfg_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_ap_start", 64'(ap_start), 64'd0);
        check("rst_mem_en", 64'(mem_en), 64'd0);
        check("rst_pix_ready", 64'(pix_ready), 64'd0);
        check("rst_core_rst", 64'(core_rst), 64'd0);
        check("rst_width", 64'(width), 64'd0);
        rst = 0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) run_job(jobs[i]);

        // Reset in the middle of a load: abort immediately, no result record.
        cfg_valid = 1; cfg_width = 16'd16; cfg_height = 16'd16;
        @(negedge clk);
        cfg_valid = 0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            pix_valid = 1;
            pix_data = DW'(i + 7);
            if (pix_ready) begin
                exp_wr_q.push_back({AW'(cnt), pix_data});
                cnt++;
            end
            @(negedge clk);
        end
        pix_valid = 0;
        check("midrst_loading", 64'(busy), 64'd1);
        @(negedge clk);
        #2 rst = 1;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_cfg_ready", 64'(cfg_ready), 64'd1);
        check("midrst_pix_ready", 64'(pix_ready), 64'd0);
        check("midrst_mem_en", 64'(mem_en), 64'd0);
        exp_wr_q.delete();
        @(negedge clk);
        rst = 0;
        repeat (5) @(negedge clk);
        check("midrst_no_result", 64'(res_valid), 64'd0);
        check("midrst_idle", 64'(busy), 64'd0);

        run_job(jobs[6]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "global timeout");
    end

endmodule
